// File: rtl/fwd_hazard_if.sv
// ---------------------------------------------------------------------------
// fwd_hazard_if
// Bundles the decode-side request, the later-stage result bus and the
// resolved-operand / stall response of the forwarding and hazard unit.
//
// Signals:
//   flush        invalidate all in-flight tags
//   hold         pipeline freeze; tags and stall counter do not advance
//   id_valid     decode stage holds a valid instruction
//   id_we        decode instruction writes a destination register
//   id_rd        decode destination register address
//   id_is_load   decode instruction is a load
//   id_rs_addr   NUM_SRC packed 5-bit source addresses
//   id_rs_data   NUM_SRC packed register-file read values
//   stage_result FWD_STAGES packed later-stage results (stage 0 = youngest)
//   opnd         NUM_SRC packed resolved operands
//   fwd_sel      NUM_SRC packed select codes (0 = regfile, k+1 = stage k)
//   stall        load-use stall
//   stall_cnt    saturating count of stall cycles
//
// Modports: master drives the request side, slave is the hazard unit.
// ---------------------------------------------------------------------------
interface fwd_hazard_if #(
    parameter int XLEN       = 32,
    parameter int NUM_SRC    = 2,
    parameter int FWD_STAGES = 2
);
    localparam int SELW = $clog2(FWD_STAGES + 1);

    logic                         flush;
    logic                         hold;
    logic                         id_valid;
    logic                         id_we;
    logic [4:0]                   id_rd;
    logic                         id_is_load;
    logic [NUM_SRC*5-1:0]         id_rs_addr;
    logic [NUM_SRC*XLEN-1:0]      id_rs_data;
    logic [FWD_STAGES*XLEN-1:0]   stage_result;
    logic [NUM_SRC*XLEN-1:0]      opnd;
    logic [NUM_SRC*SELW-1:0]      fwd_sel;
    logic                         stall;
    logic [31:0]                  stall_cnt;

    modport master (
        output flush, hold, id_valid, id_we, id_rd, id_is_load,
               id_rs_addr, id_rs_data, stage_result,
        input  opnd, fwd_sel, stall, stall_cnt
    );

    modport slave (
        input  flush, hold, id_valid, id_we, id_rd, id_is_load,
               id_rs_addr, id_rs_data, stage_result,
        output opnd, fwd_sel, stall, stall_cnt
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit
// Operand-forwarding and load-use hazard unit. Destination tags of issued
// instructions ride a FWD_STAGES-deep shift pipeline; each decode source is
// taken from the youngest later stage that will write it, otherwise from the
// register file. A source whose youngest producer is a load that has not yet
// reached LOAD_STAGE raises stall, and stall cycles are counted.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset (clears tags and stall counter)
//   bus   fwd_hazard_if.slave: decode request, stage results, resolved
//         operands, select codes, stall and stall counter
// ---------------------------------------------------------------------------
module fwd_hazard_unit #(
    parameter int XLEN       = 32,
    parameter int NUM_SRC    = 2,
    parameter int FWD_STAGES = 2,
    parameter int LOAD_STAGE = 1
) (
    input  logic          clk,
    input  logic          rst,
    fwd_hazard_if.slave   bus
);
    localparam int SELW = $clog2(FWD_STAGES + 1);

    logic              r_tag_v  [FWD_STAGES];
    logic [4:0]        r_tag_rd [FWD_STAGES];
    logic              r_tag_ld [FWD_STAGES];
    logic [31:0]       r_stall_cnt;

    logic                    w_issue;
    logic                    w_stall;
    logic [NUM_SRC-1:0]      w_src_stall;
    logic [NUM_SRC*SELW-1:0] w_fwd_sel;
    logic [NUM_SRC*XLEN-1:0] w_opnd;

    // x0 is never tracked; a stalled instruction is not issued, a bubble is.
    assign w_issue = bus.id_valid & ~w_stall & bus.id_we & (bus.id_rd != 5'd0);

    // ---- tag pipeline: decode -> stage 0 -> ... -> stage FWD_STAGES-1 ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < FWD_STAGES; k++) r_tag_v[k] <= 1'b0;
        end else if (bus.flush) begin
            for (int k = 0; k < FWD_STAGES; k++) r_tag_v[k] <= 1'b0;
        end else if (!bus.hold) begin
            r_tag_v[0] <= w_issue;
            for (int k = 1; k < FWD_STAGES; k++) r_tag_v[k] <= r_tag_v[k-1];
        end
    end

    // Address/load fields are qualified by the valid bit, so they need no reset.
    always_ff @(posedge clk) begin
        if (!bus.hold) begin
            r_tag_rd[0] <= bus.id_rd;
            r_tag_ld[0] <= bus.id_is_load;
            for (int k = 1; k < FWD_STAGES; k++) begin
                r_tag_rd[k] <= r_tag_rd[k-1];
                r_tag_ld[k] <= r_tag_ld[k-1];
            end
        end
    end

    // Scan oldest to youngest so the youngest match is the one left standing;
    // the stall decision follows that same winner only.
    always_comb begin
        w_fwd_sel   = '0;
        w_opnd      = '0;
        w_src_stall = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_opnd[i*XLEN +: XLEN] = bus.id_rs_data[i*XLEN +: XLEN];
            for (int k = FWD_STAGES - 1; k >= 0; k--) begin
                if ((bus.id_rs_addr[i*5 +: 5] != 5'd0) && r_tag_v[k] &&
                    (r_tag_rd[k] == bus.id_rs_addr[i*5 +: 5])) begin
                    w_fwd_sel[i*SELW +: SELW] = SELW'(k + 1);
                    w_opnd[i*XLEN +: XLEN]    = bus.stage_result[k*XLEN +: XLEN];
                    w_src_stall[i]            = r_tag_ld[k] && (k < LOAD_STAGE);
                end
            end
        end
    end

    assign w_stall = bus.id_valid & ~bus.flush & (|w_src_stall);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && !bus.hold && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign bus.opnd      = w_opnd;
    assign bus.fwd_sel   = w_fwd_sel;
    assign bus.stall     = w_stall;
    assign bus.stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fwd_hazard_if #(.XLEN(32), .NUM_SRC(2), .FWD_STAGES(2)) bus ();

    fwd_hazard_unit #(.XLEN(32), .NUM_SRC(2), .FWD_STAGES(2), .LOAD_STAGE(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [1:0]  sel0;
        logic [1:0]  sel1;
        logic [31:0] op0;
        logic [31:0] op1;
        logic        stall;
        logic [31:0] cnt;
    } obs_t;

    localparam logic [31:0] RF0 = 32'h1111_1111;
    localparam logic [31:0] RF1 = 32'h2222_2222;

    obs_t exp_q[$];
    obs_t got, want;
    int   n_checks = 0;
    int   n_err    = 0;

    function automatic obs_t mk(input logic [1:0] s0, input logic [1:0] s1,
                                input logic [31:0] o0, input logic [31:0] o1,
                                input logic st, input logic [31:0] c);
        obs_t o;
        o.sel0 = s0; o.sel1 = s1; o.op0 = o0; o.op1 = o1; o.stall = st; o.cnt = c;
        return o;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.sel0  = bus.fwd_sel[1:0];
        o.sel1  = bus.fwd_sel[3:2];
        o.op0   = bus.opnd[31:0];
        o.op1   = bus.opnd[63:32];
        o.stall = bus.stall;
        o.cnt   = bus.stall_cnt;
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [4:0] rd,
                         input logic ld, input logic [4:0] rs0, input logic [4:0] rs1);
        bus.id_valid   = v;
        bus.id_we      = we;
        bus.id_rd      = rd;
        bus.id_is_load = ld;
        bus.id_rs_addr = {rs1, rs0};
    endtask

    task automatic clear_tags();
        tick();
        drive(0, 0, 0, 0, 0, 0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
    endtask

    task automatic test_reset();
        drive(1, 1, 5, 0, 5, 5);
        tick();
        tick();
        exp_q.push_back(mk(0, 0, RF0, RF1, 0, 0));
        #4;
        got = observe(); want = exp_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_err++; $display("FAIL reset_state: got %h want %h", got, want);
        end
        #1 rst = 1'b0;
    endtask

    task automatic test_forward();
        tick();
        drive(1, 1, 5, 0, 0, 0);
        tick();
        bus.stage_result[31:0] = 32'h0000_1234;
        drive(1, 0, 0, 0, 5, 0);
        exp_q.push_back(mk(1, 0, 32'h0000_1234, RF1, 0, 0));
        #4;
        got = observe(); want = exp_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_err++; $display("FAIL fwd_basic: got %h want %h", got, want);
        end
        bus.stage_result[31:0] = 32'h0000_0001;
    endtask

    task automatic test_priority();
        clear_tags();
        tick(); drive(1, 1, 5, 0, 0, 0);
        tick(); drive(1, 1, 5, 0, 0, 0);
        tick(); drive(1, 0, 0, 0, 5, 5);
        exp_q.push_back(mk(1, 1, 32'h1, 32'h1, 0, 0));
        #4;
        got = observe(); want = exp_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_err++; $display("FAIL fwd_youngest: got %h want %h", got, want);
        end
        clear_tags();
        tick(); drive(1, 1, 5, 0, 0, 0);
        tick(); drive(1, 1, 9, 0, 0, 0);
        tick(); drive(1, 0, 0, 0, 5, 9);
        exp_q.push_back(mk(2, 1, 32'h2, 32'h1, 0, 0));
        #4;
        got = observe(); want = exp_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_err++; $display("FAIL fwd_depth: got %h want %h", got, want);
        end
    endtask

    task automatic test_load_use();
        clear_tags();
        tick(); drive(1, 1, 7, 1, 0, 0);
        tick(); drive(1, 1, 8, 0, 7, 0);
        exp_q.push_back(mk(1, 0, 32'h1, RF1, 1, 0));
        exp_q.push_back(mk(2, 0, 32'h2, RF1, 0, 1));
        for (int c = 0; c < 2; c++) begin
            if (c > 0) tick();
            #4;
            got = observe(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_err++; $display("FAIL load_use_c%0d: got %h want %h", c, got, want);
            end
        end
    endtask

    task automatic test_youngest_load();
        clear_tags();
        tick(); drive(1, 1, 7, 0, 0, 0);
        tick(); drive(1, 1, 7, 1, 0, 0);
        tick(); drive(1, 0, 0, 0, 7, 0);
        exp_q.push_back(mk(1, 0, 32'h1, RF1, 1, 1));
        exp_q.push_back(mk(2, 0, 32'h2, RF1, 0, 2));
        for (int c = 0; c < 2; c++) begin
            if (c > 0) tick();
            #4;
            got = observe(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_err++; $display("FAIL young_load_c%0d: got %h want %h", c, got, want);
            end
        end
    endtask

    task automatic test_x0();
        clear_tags();
        tick(); drive(1, 1, 3, 0, 0, 0);
        tick(); drive(1, 1, 0, 0, 0, 0);
        tick(); drive(1, 0, 0, 0, 0, 3);
        bus.id_rs_data[31:0] = 32'h0;
        exp_q.push_back(mk(0, 2, 32'h0, 32'h2, 0, 2));
        #4;
        got = observe(); want = exp_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_err++; $display("FAIL x0_fwd: got %h want %h", got, want);
        end
        n_checks++;
        if (dut.r_tag_v[0] !== 1'b0) begin
            n_err++; $display("FAIL x0_tag0_valid: got %b want 0", dut.r_tag_v[0]);
        end
        bus.id_rs_data[31:0] = RF0;
    endtask

    task automatic test_hold();
        clear_tags();
        tick(); drive(1, 1, 7, 1, 0, 0);
        tick(); drive(1, 1, 8, 0, 7, 0);
        for (int c = 0; c < 4; c++) exp_q.push_back(mk(1, 0, 32'h1, RF1, 1, 2));
        exp_q.push_back(mk(2, 0, 32'h2, RF1, 0, 3));
        for (int c = 0; c < 5; c++) begin
            if (c > 0) tick();
            bus.hold = (c < 3);
            #4;
            got = observe(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_err++; $display("FAIL hold_c%0d: got %h want %h", c, got, want);
            end
        end
        bus.hold = 1'b0;
    endtask

    task automatic test_flush();
        clear_tags();
        tick(); drive(1, 1, 7, 1, 0, 0);
        tick(); drive(1, 1, 8, 0, 7, 0);
        bus.flush = 1'b1;
        exp_q.push_back(mk(1, 0, 32'h1, RF1, 0, 3));
        #4;
        got = observe(); want = exp_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_err++; $display("FAIL flush_same_cycle: got %h want %h", got, want);
        end
        tick();
        bus.flush = 1'b0;
        drive(1, 0, 0, 0, 7, 8);
        exp_q.push_back(mk(0, 0, RF0, RF1, 0, 3));
        #4;
        got = observe(); want = exp_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_err++; $display("FAIL flush_after: got %h want %h", got, want);
        end
    endtask

    task automatic test_async_reset();
        clear_tags();
        tick(); drive(1, 1, 7, 1, 0, 0);
        tick(); drive(1, 1, 8, 0, 7, 0);
        tick(); drive(0, 0, 0, 0, 7, 0);
        exp_q.push_back(mk(2, 0, 32'h2, RF1, 0, 4));
        #4;
        got = observe(); want = exp_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_err++; $display("FAIL pre_reset: got %h want %h", got, want);
        end
        #1 rst = 1'b1;
        exp_q.push_back(mk(0, 0, RF0, RF1, 0, 0));
        #1;
        got = observe(); want = exp_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_err++; $display("FAIL async_reset: got %h want %h", got, want);
        end
        #1 rst = 1'b0;
        tick(); drive(1, 1, 5, 0, 0, 0);
        tick(); drive(0, 0, 0, 0, 5, 0);
        exp_q.push_back(mk(1, 0, 32'h1, RF1, 0, 0));
        #4;
        got = observe(); want = exp_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_err++; $display("FAIL post_reset_fwd: got %h want %h", got, want);
        end
    endtask

    initial begin
        bus.flush        = 1'b0;
        bus.hold         = 1'b0;
        bus.id_rs_data   = {RF1, RF0};
        bus.stage_result = {32'h0000_0002, 32'h0000_0001};
        drive(0, 0, 0, 0, 0, 0);
        test_reset();
        test_forward();
        test_priority();
        test_load_use();
        test_youngest_load();
        test_x0();
        test_hold();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised operand-forwarding and load-use hazard unit for the integer pipeline.
- Tracks the destination tags of in-flight instructions in a FWD_STAGES-deep shift pipeline.
- Selects each of NUM_SRC decode-stage source operands from the register file or the youngest matching later stage.
- Raises a load-use stall when a load result is not yet available, and keeps a saturating stall-cycle counter.

Parameters:
XLEN, 32, datapath width
NUM_SRC, 2, number of source operands resolved per cycle
FWD_STAGES, 2, number of later stages forwarded from; stage 0 is youngest (EX), stage FWD_STAGES-1 oldest (WB)
LOAD_STAGE, 1, first stage index whose result is valid for a load; range 0..FWD_STAGES-1
SELW, $clog2(FWD_STAGES+1), width of one select code (derived)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  invalidate all in-flight tags
hold  in  1  pipeline freeze; tags and counter do not advance
id_valid  in  1  decode stage holds a valid instruction
id_we  in  1  instruction writes a destination register
id_rd  in  5  destination register address
id_is_load  in  1  instruction is a load
id_rs_addr  in  NUM_SRC*5  source addresses; source i at bits [i*5 +: 5]
id_rs_data  in  NUM_SRC*XLEN  register-file read data, packed the same way
stage_result  in  FWD_STAGES*XLEN  result of stage k at bits [k*XLEN +: XLEN]
opnd  out  NUM_SRC*XLEN  resolved operands
fwd_sel  out  NUM_SRC*SELW  per source: 0 = register file, k+1 = stage k
stall  out  1  load-use stall; decode must hold its instruction
stall_cnt  out  32  saturating count of stall cycles

Behaviour:
Tag format:
- Each stage tag is {v, rd[4:0], ld}.

Tag update (async reset, otherwise registered):
- rst: all v=0. No other state exists besides tags and stall_cnt.
- Otherwise, priority is flush > hold > shift.
- flush: all v=0.
- hold: tags unchanged.
- shift: tag[k] <= tag[k-1] for k ≥ 1.
- tag[0] <= {1, id_rd, id_is_load} only when id_valid & ~stall & id_we & (id_rd != 0). Otherwise tag[0].v <= 0, which inserts a bubble.

Match (combinational, per source i):
- Condition: id_rs_addr[i] != 0 and tag[k].v and tag[k].rd == id_rs_addr[i].
- The youngest match (lowest k) wins.
- No match, or rs == 0: fwd_sel = 0 and opnd = id_rs_data[i].
- Match in stage k: fwd_sel = k+1 and opnd = stage_result[k].
- Forwarding applies even when id_valid = 0 (operands are don't-care). Stall requires id_valid.

Stall (combinational):
- stall = id_valid & ~flush & OR over i of (the winning match tag has ld=1 and k < LOAD_STAGE).
- While stall is high, fwd_sel/opnd still reflect the match. Decode ignores them.
- Only the youngest match is considered. An older non-load match never masks a younger unresolved load.

stall_cnt:
- Increments on each rising edge where stall & ~hold.
- Saturates at 0xFFFFFFFF.
- Cleared only by rst; flush does not clear it.

Latency:
- Zero-cycle (combinational) from id_*/stage_result to opnd, fwd_sel and stall.
- One cycle from issue to tag visibility in stage 0.

Reset values:
- stall_cnt = 0.
- All tags invalid, so fwd_sel = 0, stall = 0, opnd = id_rs_data.
- Reset asserted mid-operation takes effect immediately, without waiting for a clock edge.

Boundary conditions:
- x0 is never tracked and never forwarded.
- Simultaneous flush and stall-causing input: stall = 0, and no tag is inserted.
- hold with stall high: tags frozen and counter not incremented. stall stays high until a shift retires the load past LOAD_STAGE.
- FWD_STAGES = 1 is legal. LOAD_STAGE = 0 means loads never stall.

Test Plan:
1. Defaults. Issue id_rd=5, we=1 at cycle n. At cycle n+1 set id_rs_addr[0]=5 and stage_result[0]=0x00001234 → fwd_sel[0]=1, opnd[0]=0x00001234, stall=0.
2. Priority and depth:
   - Issue rd=5, then rd=5 again, then rs0=5 and rs1=5 with stage_result[0]=0x1 and stage_result[1]=0x2 → both sources select 1 with opnd 0x1.
   - Repeat with an intervening rd=9 so rd=5 sits only in stage 1 → sel=2, opnd 0x2.
3. Load-use:
   - Issue load rd=7, then id_valid with rs0=7 → stall=1 for exactly one cycle, stall_cnt 0→1.
   - The next cycle gives stall=0, fwd_sel[0]=2, opnd[0]=stage_result[1].
4. x0:
   - Issue we=1, rd=0, then rs0=0 with id_rs_data[0]=0 → fwd_sel=0, opnd=0.
   - Stage 0 tag is invalid on the cycle after the rd=0 issue.
5. hold/flush:
   - During a load-use stall, assert hold for 3 cycles → stall stays 1 and stall_cnt unchanged. Release → one more stall cycle counted.
   - Assert flush with tags valid → next cycle all fwd_sel=0, and flush in the same cycle forces stall=0.
6. Async reset:
   - With tags valid and stall_cnt=4, assert rst between clock edges → fwd_sel=0, stall=0, stall_cnt=0 before the next edge.
   - After release, the first issue forwards normally.
